commit_trace_buffer: RTL and testbench

- Synthesizable retirement-trace buffer for the multi-cycle CPU; replaces the bench-only sampling of debug commit signals.
- Captures up to NUM_CH commit events per cycle, each as {pc, instruction}. Sources include the WB non-store commit and the MEM store commit, and others.
- Stores them in program order in a DEPTH-entry FIFO with a global sequence number.
- Drains them over a valid/ready port to a checker or trace sink. Overflow is reported, never silent.

---
 rtl/commit_trace_buffer_if.sv | 50 +++++
 rtl/commit_trace_buffer.sv | 128 ++++++++++++
 tb/tb_commit_trace_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_buffer_if.sv
// +--------------------------------------------------------------------------+
// | commit_trace_buffer_if : commit capture and trace drain bundle            |
// | Optional: COMMIT_TRACE_CYCLE_STAMP_EN adds trace_cycle_o.  Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

interface commit_trace_buffer_if #(
  parameter int NUM_CH      = 2,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int SEQ_WIDTH   = 16,
  parameter int DROP_WIDTH  = 8
);
  logic [NUM_CH-1:0]               commit_valid_i;
  logic [NUM_CH*ADDR_WIDTH-1:0]    commit_pc_i;
  logic [NUM_CH*INSTR_WIDTH-1:0]   commit_instr_i;
  logic                            flush_i;
  logic                            trace_valid_o;
  logic                            trace_ready_i;
  logic [ADDR_WIDTH-1:0]           trace_pc_o;
  logic [INSTR_WIDTH-1:0]          trace_instr_o;
  logic [SEQ_WIDTH-1:0]            trace_seq_o;
  logic [$clog2(DEPTH+1)-1:0]      count_o;
  logic                            overflow_o;
  logic [DROP_WIDTH-1:0]           drop_count_o;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  logic [31:0]                     trace_cycle_o;
`endif

  modport master (
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    input  trace_cycle_o,
`endif
    output commit_valid_i, commit_pc_i, commit_instr_i, flush_i, trace_ready_i,
    input  trace_valid_o, trace_pc_o, trace_instr_o, trace_seq_o,
    input  count_o, overflow_o, drop_count_o
  );

  modport slave (
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    output trace_cycle_o,
`endif
    input  commit_valid_i, commit_pc_i, commit_instr_i, flush_i, trace_ready_i,
    output trace_valid_o, trace_pc_o, trace_instr_o, trace_seq_o,
    output count_o, overflow_o, drop_count_o
  );
endinterface

`default_nettype wire

// File: rtl/commit_trace_buffer.sv
// +--------------------------------------------------------------------------+
// | commit_trace_buffer : in-order retirement trace FIFO with seq numbering   |
// | Optional: COMMIT_TRACE_CYCLE_STAMP_EN stamps entries.  Rev 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module commit_trace_buffer #(
  parameter int NUM_CH      = 2,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int SEQ_WIDTH   = 16,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  commit_trace_buffer_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0]          head, tail;
  logic [CW-1:0]          count;
  logic [SEQ_WIDTH-1:0]   seq_cnt;
  logic                   overflow;
  logic [DROP_WIDTH-1:0]  drop_cnt;

  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [SEQ_WIDTH-1:0]   seq_mem   [DEPTH];

  logic                   not_empty, pop;
  logic [CW-1:0]          free, n_valid, n_push, n_drop;
  logic [CW-1:0]          rank    [NUM_CH];
  logic [NUM_CH-1:0]      wr_en;
  logic [IW-1:0]          wr_slot [NUM_CH];
  logic [DROP_WIDTH:0]    drop_sum;

  assign not_empty = (count != '0);
  assign pop       = not_empty && bus.trace_ready_i;
  assign free      = CW'(DEPTH) - count + CW'(pop);

  // Rank = number of lower-index valid channels; it selects both the
  // compacted tail slot and the sequence offset of each channel.
  always_comb begin
    n_valid = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rank[k]    = n_valid;
      wr_slot[k] = tail + rank[k][IW-1:0];
      wr_en[k]   = bus.commit_valid_i[k] && (rank[k] < free) && !bus.flush_i;
      if (bus.commit_valid_i[k]) n_valid = n_valid + CW'(1);
    end
  end

  assign n_push   = (n_valid < free) ? n_valid : free;
  assign n_drop   = n_valid - n_push;
  assign drop_sum = {1'b0, drop_cnt} + (DROP_WIDTH+1)'(n_drop);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      seq_cnt  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      // Every valid commit burns a sequence number, even when flushed or dropped.
      seq_cnt <= seq_cnt + SEQ_WIDTH'(n_valid);
      if (bus.flush_i) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else begin
        head  <= head + IW'(pop);
        tail  <= tail + IW'(n_push);
        count <= count + n_push - CW'(pop);
        if (n_drop != '0) overflow <= 1'b1;
        drop_cnt <= drop_sum[DROP_WIDTH] ? {DROP_WIDTH{1'b1}} : drop_sum[DROP_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en[k]) begin
          pc_mem[wr_slot[k]]    <= bus.commit_pc_i[k*ADDR_WIDTH +: ADDR_WIDTH];
          instr_mem[wr_slot[k]] <= bus.commit_instr_i[k*INSTR_WIDTH +: INSTR_WIDTH];
          seq_mem[wr_slot[k]]   <= seq_cnt + SEQ_WIDTH'(rank[k]);
        end
      end
    end
  end

  assign bus.trace_valid_o = not_empty;
  assign bus.trace_pc_o    = not_empty ? pc_mem[head]    : '0;
  assign bus.trace_instr_o = not_empty ? instr_mem[head] : '0;
  assign bus.trace_seq_o   = not_empty ? seq_mem[head]   : '0;
  assign bus.count_o       = count;
  assign bus.overflow_o    = overflow;
  assign bus.drop_count_o  = drop_cnt;

`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] cycle_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_i) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en[k]) cycle_mem[wr_slot[k]] <= cycle_cnt;
      end
    end
  end

  assign bus.trace_cycle_o = not_empty ? cycle_mem[head] : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
// +--------------------------------------------------------------------------+
// | tb_commit_trace_buffer : directed self-checking bench, 2 ch, depth 16     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_commit_trace_buffer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  commit_trace_buffer_if #(.NUM_CH(2), .DEPTH(16)) bus ();

  commit_trace_buffer #(.NUM_CH(2), .DEPTH(16)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  logic [31:0] tb_cyc;
  logic [31:0] stamp_exp;
  always @(posedge clk) begin
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] i0,
                       input logic [31:0] p1, input logic [31:0] i1);
    bus.commit_valid_i = v;
    bus.commit_pc_i    = {p1, p0};
    bus.commit_instr_i = {i1, i0};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b00, 0, 0, 0, 0);
    bus.flush_i       = 1'b0;
    bus.trace_ready_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    do_reset();
    check("rst_valid", bus.trace_valid_o, 0);
    check("rst_count", bus.count_o, 0);
    check("rst_pc", bus.trace_pc_o, 0);
    check("rst_seq", bus.trace_seq_o, 0);
    check("rst_ovf", bus.overflow_o, 0);
    check("rst_drop", bus.drop_count_o, 0);

    // Single commit, sink stalled
    drive(2'b01, 32'h1, 32'h4470, 0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    check("t1_valid", bus.trace_valid_o, 1);
    check("t1_pc", bus.trace_pc_o, 32'h1);
    check("t1_instr", bus.trace_instr_o, 32'h4470);
    check("t1_seq", bus.trace_seq_o, 0);
    check("t1_count", bus.count_o, 1);

    // Dual commit, drained in channel order
    do_reset();
    bus.trace_ready_i = 1'b1;
    drive(2'b11, 32'h5, 32'h36212, 32'h6, 32'hFFFF50E2);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    check("t2_pc0", bus.trace_pc_o, 32'h5);
    check("t2_instr0", bus.trace_instr_o, 32'h36212);
    check("t2_seq0", bus.trace_seq_o, 0);
    check("t2_count0", bus.count_o, 2);
    tick();
    check("t2_pc1", bus.trace_pc_o, 32'h6);
    check("t2_instr1", bus.trace_instr_o, 32'hFFFF50E2);
    check("t2_seq1", bus.trace_seq_o, 1);
    check("t2_count1", bus.count_o, 1);
    tick();
    check("t2_empty", bus.trace_valid_o, 0);
    check("t2_mask", bus.trace_pc_o, 0);
    check("t2_count2", bus.count_o, 0);

    // Continuous streaming through the wrap point
    do_reset();
    bus.trace_ready_i = 1'b1;
    for (int j = 0; j <= 20; j++) begin
      if (j < 20) drive(2'b01, 32'h1000 + j, 32'hA000 + j, 0, 0);
      else        drive(2'b00, 0, 0, 0, 0);
      if (j == 0) begin
        check("t5_empty0", bus.trace_valid_o, 0);
      end else begin
        check("t5_valid", bus.trace_valid_o, 1);
        check("t5_pc", bus.trace_pc_o, 32'h1000 + j - 1);
        check("t5_seq", bus.trace_seq_o, j - 1);
        check("t5_count_le2", bus.count_o <= 2, 1);
      end
      tick();
    end
    check("t5_done", bus.trace_valid_o, 0);

    // Fill to DEPTH with the sink stalled, then overflow both channels
    bus.trace_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 32'h100 + 2*i, 32'hB0, 32'h101 + 2*i, 32'hB1);
      tick();
    end
    check("t3_full", bus.count_o, 16);
    check("t3_noovf", bus.overflow_o, 0);
    drive(2'b11, 32'h200, 0, 32'h201, 0);
    tick();
    check("t3_count", bus.count_o, 16);
    check("t3_ovf", bus.overflow_o, 1);
    check("t3_drop", bus.drop_count_o, 2);
    check("t3_head_pc", bus.trace_pc_o, 32'h100);
    check("t3_head_seq", bus.trace_seq_o, 20);

    // Full with a pop: one slot frees, ch0 enters, ch1 drops
    bus.trace_ready_i = 1'b1;
    drive(2'b11, 32'h300, 32'hC0, 32'h301, 32'hC1);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    check("t4_count", bus.count_o, 16);
    check("t4_drop", bus.drop_count_o, 3);
    for (int i = 0; i < 15; i++) begin
      check("t4_drain_pc", bus.trace_pc_o, 32'h101 + i);
      check("t4_drain_seq", bus.trace_seq_o, 21 + i);
      tick();
    end
    check("t4_ch0_pc", bus.trace_pc_o, 32'h300);
    check("t4_ch0_seq", bus.trace_seq_o, 38);
    drive(2'b01, 32'h500, 32'hD0, 0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    check("t4_next_pc", bus.trace_pc_o, 32'h500);
    check("t4_gap_seq", bus.trace_seq_o, 40);
    check("t4_count1", bus.count_o, 1);

    // Flush with a same-cycle commit and ready
    bus.trace_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 32'h600 + i, 32'hE0, 0, 0);
      tick();
    end
    drive(2'b00, 0, 0, 0, 0);
    check("t6_count5", bus.count_o, 5);
    bus.flush_i       = 1'b1;
    bus.trace_ready_i = 1'b1;
    drive(2'b01, 32'h700, 32'hF0, 0, 0);
    tick();
    bus.flush_i       = 1'b0;
    bus.trace_ready_i = 1'b0;
    drive(2'b00, 0, 0, 0, 0);
    check("t6_count", bus.count_o, 0);
    check("t6_valid", bus.trace_valid_o, 0);
    check("t6_ovf", bus.overflow_o, 0);
    check("t6_drop", bus.drop_count_o, 0);
    drive(2'b01, 32'h800, 32'h880, 0, 0);
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    stamp_exp = tb_cyc;
`endif
    tick();
    drive(2'b00, 0, 0, 0, 0);
    check("t6_pc", bus.trace_pc_o, 32'h800);
    check("t6_seq", bus.trace_seq_o, 46);
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    check("t6_stamp", bus.trace_cycle_o, stamp_exp);
`endif

    // Reset mid-drain overrides everything
    bus.trace_ready_i = 1'b1;
    rst_n = 1'b0;
    drive(2'b11, 32'h900, 0, 32'h901, 0);
    tick();
    rst_n = 1'b1;
    drive(2'b00, 0, 0, 0, 0);
    check("rst2_count", bus.count_o, 0);
    check("rst2_valid", bus.trace_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
